crop_capture_seq: RTL and testbench

//  Sequencer for the crop x-start detector. On a start request it aligns to
//  the 640x480 pixel stream and samples the detector's per-frame oXSTART.

---
 rtl/crop_capture_seq.sv | 187 ++++++++++++++++++
 tb/tb_crop_capture_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crop_capture_seq.sv
// Crop capture sequencer: tracks the pixel raster, waits for a stable detector x-start,
// latches the crop window and gates a single capture frame to the frame-buffer writer.
module crop_capture_seq #(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned CROP_W        = 320,
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned TOL           = 8,
    parameter int unsigned NOHIT         = 540,
    parameter int unsigned MAX_MISS      = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iABORT,
    input  logic        iDVAL,
    input  logic [15:0] iXSTART,
    output logic        oBUSY,
    output logic        oCAP_EN,
    output logic [15:0] oCROP_X0,
    output logic [15:0] oCROP_X1,
    output logic        oDONE,
    output logic        oERR,
    output logic [2:0]  oSTATE
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSync    = 3'd1;
    localparam logic [2:0] StMeasure = 3'd2;
    localparam logic [2:0] StArmed   = 3'd3;
    localparam logic [2:0] StCapture = 3'd4;

    localparam logic [15:0] XLast   = 16'(H_ACTIVE - 1);
    localparam logic [15:0] YLast   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] Tol     = 16'(TOL);
    localparam logic [15:0] NoHit   = 16'(NOHIT);
    localparam logic [7:0]  StableN = 8'(STABLE_FRAMES);
    localparam logic [7:0]  MissN   = 8'(MAX_MISS);

    logic [15:0] x_q, y_q;
    logic        fe, fe_d_q, discard_q;
    logic [2:0]  state_q, state_d;
    logic [15:0] ref_q, ref_d;
    logic [7:0]  stable_q, stable_d;
    logic [7:0]  miss_q, miss_d;
    logic [15:0] x0_q, x0_d, x1_q, x1_d;
    logic        cap_en_q, cap_en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] diff;
    logic [16:0] x1_sum;
    logic [15:0] x1_new;
    logic        in_win;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            x_q <= 16'd0;
            y_q <= 16'd0;
        end else if (iDVAL) begin
            if (x_q == XLast) begin
                x_q <= 16'd0;
                y_q <= (y_q == YLast) ? 16'd0 : y_q + 16'd1;
            end else begin
                x_q <= x_q + 16'd1;
            end
        end
    end

    assign fe     = iDVAL && (x_q == XLast) && (y_q == YLast);
    assign diff   = (iXSTART >= ref_q) ? (iXSTART - ref_q) : (ref_q - iXSTART);
    assign x1_sum = {1'b0, ref_q} + 17'(CROP_W - 1);
    assign x1_new = (x1_sum > 17'(H_ACTIVE - 1)) ? XLast : x1_sum[15:0];
    assign in_win = (x_q >= x0_q) && (x_q <= x1_q);

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        stable_d = stable_q;
        miss_d   = miss_q;
        x0_d     = x0_q;
        x1_d     = x1_q;
        cap_en_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (iSTART) begin
                    state_d  = StSync;
                    stable_d = 8'd0;
                    miss_d   = 8'd0;
                end
            end
            StSync: begin
                if (fe) state_d = StMeasure;
            end
            StMeasure: begin
                // The first fe_d after leaving SYNC carries the SYNC frame's result.
                if (fe_d_q && !discard_q) begin
                    if (iXSTART == NoHit) begin
                        stable_d = 8'd0;
                        miss_d   = miss_q + 8'd1;
                        if (miss_d == MissN) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end else begin
                        if (diff <= Tol) begin
                            stable_d = stable_q + 8'd1;
                        end else begin
                            ref_d    = iXSTART;
                            stable_d = 8'd1;
                        end
                        miss_d = 8'd0;
                        if (stable_d == StableN) begin
                            x0_d    = ref_q;
                            x1_d    = x1_new;
                            state_d = StArmed;
                        end
                    end
                end
            end
            StArmed: begin
                if (iDVAL && (x_q == 16'd0) && (y_q == 16'd0)) begin
                    state_d  = StCapture;
                    cap_en_d = in_win;
                end
            end
            StCapture: begin
                cap_en_d = iDVAL && in_win;
                if (fe) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort cancels everything this cycle would have done except the raster.
        if (iABORT) begin
            state_d  = StIdle;
            ref_d    = ref_q;
            stable_d = 8'd0;
            miss_d   = 8'd0;
            x0_d     = x0_q;
            x1_d     = x1_q;
            cap_en_d = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q   <= StIdle;
            fe_d_q    <= 1'b0;
            discard_q <= 1'b0;
            ref_q     <= 16'd0;
            stable_q  <= 8'd0;
            miss_q    <= 8'd0;
            x0_q      <= 16'd0;
            x1_q      <= 16'd0;
            cap_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fe_d_q    <= fe;
            discard_q <= (state_q == StSync) && fe;
            ref_q     <= ref_d;
            stable_q  <= stable_d;
            miss_q    <= miss_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            cap_en_q  <= cap_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign oBUSY    = (state_q != StIdle);
    assign oCAP_EN  = cap_en_q;
    assign oCROP_X0 = x0_q;
    assign oCROP_X1 = x1_q;
    assign oDONE    = done_q;
    assign oERR     = err_q;
    assign oSTATE   = state_q;

endmodule

// File: tb/tb_crop_capture_seq.sv
// Bench for crop_capture_seq: short 2-line frames, a frame-level reference model of the
// stability rules, and a per-pixel expectation of the capture enable.
module tb_crop_capture_seq;

    localparam int H_ACT = 640;
    localparam int V_ACT = 2;
    localparam int NOHIT = 540;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iSTART = 1'b0;
    logic        iABORT = 1'b0;
    logic        iDVAL = 1'b0;
    logic [15:0] iXSTART = 16'd0;
    logic        oBUSY, oCAP_EN, oDONE, oERR;
    logic [15:0] oCROP_X0, oCROP_X1;
    logic [2:0]  oSTATE;

    crop_capture_seq #(
        .H_ACTIVE(H_ACT),
        .V_ACTIVE(V_ACT)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iSTART(iSTART),
        .iABORT(iABORT),
        .iDVAL(iDVAL),
        .iXSTART(iXSTART),
        .oBUSY(oBUSY),
        .oCAP_EN(oCAP_EN),
        .oCROP_X0(oCROP_X0),
        .oCROP_X1(oCROP_X1),
        .oDONE(oDONE),
        .oERR(oERR),
        .oSTATE(oSTATE)
    );

    always #5 iCLK = ~iCLK;

    int n_chk = 0;
    int n_pass = 0;
    int px = 0, py = 0;
    logic [15:0] next_xs = 16'd0;
    bit cap_on = 1'b0;
    int x0e = 0, x1e = 0;
    int cap_cnt, cap_bad, done_cnt, err_cnt;
    int line_cnt [V_ACT];
    int st_sync, st_meas;
    int m_ref = 0, m_stable = 0, m_miss = 0;

    task automatic clear_stats();
        cap_cnt = 0; cap_bad = 0; done_cnt = 0; err_cnt = 0;
        for (int i = 0; i < V_ACT; i++) line_cnt[i] = 0;
    endtask

    // One clock cycle; px/py track the raster position of the pixel being driven.
    task automatic pixel(input bit v, input bit st, input bit ab);
        bit exp_en;
        iDVAL = v; iSTART = st; iABORT = ab;
        exp_en = v && cap_on && !ab && px >= x0e && px <= x1e;
        @(posedge iCLK);
        #1;
        iSTART = 1'b0; iABORT = 1'b0;
        if (oCAP_EN) begin
            cap_cnt++;
            line_cnt[py]++;
        end
        if (oCAP_EN !== exp_en) cap_bad++;
        if (oDONE) done_cnt++;
        if (oERR) err_cnt++;
        if (v) begin
            if (px == H_ACT - 1 && py == V_ACT - 1) iXSTART = next_xs;
            if (px == H_ACT - 1) begin
                px = 0;
                py = (py == V_ACT - 1) ? 0 : py + 1;
            end else begin
                px++;
            end
        end
    endtask

    task automatic frame(input logic [15:0] xs, input int gap_pct);
        int n;
        next_xs = xs;
        n = 0;
        while (n < H_ACT * V_ACT) begin
            if (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) begin
                pixel(1'b0, 1'b0, 1'b0);
            end else begin
                pixel(1'b1, 1'b0, 1'b0);
                n++;
            end
        end
        pixel(1'b0, 1'b0, 1'b0);
        pixel(1'b0, 1'b0, 1'b0);
    endtask

    // Frame-level reference: res 1 = window latched, 2 = too many misses.
    task automatic model_step(input logic [15:0] s, output int res);
        int d;
        res = 0;
        if (int'(s) == NOHIT) begin
            m_stable = 0;
            m_miss++;
            if (m_miss == 8) res = 2;
        end else begin
            d = (int'(s) > m_ref) ? int'(s) - m_ref : m_ref - int'(s);
            if (d <= 8) m_stable++;
            else begin
                m_ref = int'(s);
                m_stable = 1;
            end
            m_miss = 0;
            if (m_stable == 4) begin
                x0e = m_ref;
                x1e = (m_ref + 319 > 639) ? 639 : m_ref + 319;
                res = 1;
            end
        end
    endtask

    task automatic start_and_measure(input logic [15:0] s[$], input int gap, output int res,
                                     output int nused);
        pixel(1'b0, 1'b1, 1'b0);
        st_sync = int'(oSTATE);
        m_stable = 0;
        m_miss = 0;
        frame(16'($urandom_range(0, 1000)), gap);
        st_meas = int'(oSTATE);
        res = 0;
        nused = 0;
        foreach (s[i]) begin
            if (res == 0) begin
                frame(s[i], gap);
                model_step(s[i], res);
                nused++;
            end
        end
    endtask

    task automatic capture_frame(input int gap);
        cap_on = 1'b1;
        frame(16'($urandom_range(0, 1000)), gap);
        cap_on = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b1;
        @(posedge iCLK);
        #1;
        n_chk++; if (oSTATE !== 3'd0) $display("FAIL reset_state got %0d want 0", oSTATE); else n_pass++;
        n_chk++; if (oBUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", oBUSY); else n_pass++;
        n_chk++;
        if ({oCAP_EN, oDONE, oERR} !== 3'b000)
            $display("FAIL reset_pulses got %b want 000", {oCAP_EN, oDONE, oERR});
        else n_pass++;
        n_chk++;
        if (oCROP_X0 !== 16'd0 || oCROP_X1 !== 16'd0)
            $display("FAIL reset_crop got %0d/%0d want 0/0", oCROP_X0, oCROP_X1);
        else n_pass++;
    endtask

    task automatic test_basic();
        int res, nu;
        logic [15:0] s[$];
        clear_stats();
        s = '{16'd200, 16'd200, 16'd200, 16'd200, 16'd200};
        start_and_measure(s, 0, res, nu);
        n_chk++; if (st_sync != 1) $display("FAIL basic_sync got %0d want 1", st_sync); else n_pass++;
        n_chk++; if (st_meas != 2) $display("FAIL basic_meas got %0d want 2", st_meas); else n_pass++;
        n_chk++; if (res != 1 || nu != 4) $display("FAIL basic_latch_frame got %0d want 4", nu); else n_pass++;
        n_chk++; if (oSTATE !== 3'd3) $display("FAIL basic_armed got %0d want 3", oSTATE); else n_pass++;
        n_chk++;
        if (oCROP_X0 !== 16'd200 || oCROP_X1 !== 16'd519)
            $display("FAIL basic_crop got %0d/%0d want 200/519", oCROP_X0, oCROP_X1);
        else n_pass++;
        capture_frame(0);
        n_chk++; if (cap_cnt != 640) $display("FAIL basic_cap_cnt got %0d want 640", cap_cnt); else n_pass++;
        n_chk++; if (cap_bad != 0) $display("FAIL basic_cap_bad got %0d want 0", cap_bad); else n_pass++;
        n_chk++; if (done_cnt != 1) $display("FAIL basic_done got %0d want 1", done_cnt); else n_pass++;
        n_chk++; if (oSTATE !== 3'd0) $display("FAIL basic_idle got %0d want 0", oSTATE); else n_pass++;
    endtask

    task automatic test_restabilise();
        int res, nu;
        logic [15:0] s[$];
        clear_stats();
        s = '{16'd200, 16'd205, 16'd198, 16'd300, 16'd301, 16'd302, 16'd303};
        start_and_measure(s, 0, res, nu);
        n_chk++; if (res != 1 || nu != 7) $display("FAIL restab_frame got %0d want 7", nu); else n_pass++;
        n_chk++;
        if (oCROP_X0 !== 16'd300 || oCROP_X1 !== 16'd619)
            $display("FAIL restab_crop got %0d/%0d want 300/619", oCROP_X0, oCROP_X1);
        else n_pass++;
        capture_frame(0);
        n_chk++; if (cap_cnt != 640 || cap_bad != 0) $display("FAIL restab_cap got %0d/%0d want 640/0", cap_cnt, cap_bad); else n_pass++;
    endtask

    task automatic test_saturate();
        int res, nu;
        logic [15:0] s[$];
        clear_stats();
        s = '{16'd500, 16'd500, 16'd500, 16'd500};
        start_and_measure(s, 0, res, nu);
        n_chk++;
        if (oCROP_X0 !== 16'd500 || oCROP_X1 !== 16'd639)
            $display("FAIL sat_crop got %0d/%0d want 500/639", oCROP_X0, oCROP_X1);
        else n_pass++;
        capture_frame(0);
        n_chk++; if (line_cnt[0] != 140) $display("FAIL sat_line0 got %0d want 140", line_cnt[0]); else n_pass++;
        n_chk++; if (line_cnt[1] != 140) $display("FAIL sat_line1 got %0d want 140", line_cnt[1]); else n_pass++;
        n_chk++; if (cap_bad != 0 || done_cnt != 1) $display("FAIL sat_cap got %0d/%0d want 0/1", cap_bad, done_cnt); else n_pass++;
    endtask

    task automatic test_nohit();
        int res, nu;
        logic [15:0] s[$];
        clear_stats();
        for (int i = 0; i < 8; i++) s.push_back(16'(NOHIT));
        start_and_measure(s, 0, res, nu);
        n_chk++; if (res != 2 || nu != 8) $display("FAIL nohit_model got %0d want 8", nu); else n_pass++;
        n_chk++; if (err_cnt != 1) $display("FAIL nohit_err got %0d want 1", err_cnt); else n_pass++;
        n_chk++; if (oSTATE !== 3'd0) $display("FAIL nohit_idle got %0d want 0", oSTATE); else n_pass++;
        n_chk++; if (cap_cnt != 0 || done_cnt != 0) $display("FAIL nohit_cap got %0d/%0d want 0/0", cap_cnt, done_cnt); else n_pass++;
    endtask

    task automatic test_abort();
        int res, nu;
        logic [15:0] s[$];
        clear_stats();
        s = '{16'd250, 16'd250, 16'd250, 16'd250};
        start_and_measure(s, 0, res, nu);
        cap_on = 1'b1;
        while (!(py == 1 && px == 100)) pixel(1'b1, 1'b0, 1'b0);
        cap_on = 1'b0;
        pixel(1'b1, 1'b0, 1'b1);
        n_chk++; if (oSTATE !== 3'd0) $display("FAIL abort_state got %0d want 0", oSTATE); else n_pass++;
        n_chk++; if (oCAP_EN !== 1'b0) $display("FAIL abort_cap_en got %b want 0", oCAP_EN); else n_pass++;
        while (!(py == 0 && px == 0)) pixel(1'b1, 1'b0, 1'b0);
        pixel(1'b0, 1'b0, 1'b0);
        n_chk++; if (done_cnt != 0) $display("FAIL abort_done got %0d want 0", done_cnt); else n_pass++;
        n_chk++; if (cap_cnt != 320 || cap_bad != 0) $display("FAIL abort_cap got %0d/%0d want 320/0", cap_cnt, cap_bad); else n_pass++;
        n_chk++; if (oCROP_X0 !== 16'd250) $display("FAIL abort_hold_x0 got %0d want 250", oCROP_X0); else n_pass++;
        pixel(1'b0, 1'b1, 1'b1);
        pixel(1'b0, 1'b0, 1'b0);
        n_chk++; if (oSTATE !== 3'd0) $display("FAIL start_abort_idle got %0d want 0", oSTATE); else n_pass++;
    endtask

    task automatic test_midframe_start();
        int res;
        clear_stats();
        next_xs = 16'd999;
        repeat (300) pixel(1'b1, 1'b0, 1'b0);
        pixel(1'b1, 1'b1, 1'b0);
        n_chk++; if (oSTATE !== 3'd1) $display("FAIL mid_sync got %0d want 1", oSTATE); else n_pass++;
        m_stable = 0;
        m_miss = 0;
        repeat (H_ACT * V_ACT - 301) pixel(1'b1, 1'b0, 1'b0);
        pixel(1'b0, 1'b0, 1'b0);
        pixel(1'b0, 1'b0, 1'b0);
        n_chk++; if (oSTATE !== 3'd2) $display("FAIL mid_meas got %0d want 2", oSTATE); else n_pass++;
        res = 0;
        for (int i = 0; i < 4; i++) begin
            frame(16'd400, 20);
            model_step(16'd400, res);
            if (i == 1) pixel(1'b0, 1'b1, 1'b0);
        end
        n_chk++;
        if (oSTATE !== 3'd3 || oCROP_X0 !== 16'd400 || oCROP_X1 !== 16'd639)
            $display("FAIL mid_latch got st%0d %0d/%0d want st3 400/639", oSTATE, oCROP_X0, oCROP_X1);
        else n_pass++;
        capture_frame(20);
        n_chk++; if (cap_cnt != 480 || cap_bad != 0) $display("FAIL mid_cap got %0d/%0d want 480/0", cap_cnt, cap_bad); else n_pass++;
        n_chk++; if (done_cnt != 1) $display("FAIL mid_done got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_random();
        int res, n, base, r;
        logic [15:0] s;
        for (int k = 0; k < 2; k++) begin
            clear_stats();
            pixel(1'b0, 1'b1, 1'b0);
            m_stable = 0;
            m_miss = 0;
            frame(16'($urandom_range(0, 1000)), 5);
            base = int'($urandom_range(4, 700));
            res = 0;
            n = 0;
            while (res == 0 && n < 12) begin
                r = int'($urandom_range(0, 9));
                if (r == 0) s = 16'(NOHIT);
                else if (r == 1) s = 16'($urandom_range(0, 1000));
                else s = 16'(base + int'($urandom_range(0, 8)) - 4);
                frame(s, 5);
                model_step(s, res);
                n++;
            end
            if (res == 1) begin
                n_chk++;
                if (int'(oCROP_X0) != x0e || int'(oCROP_X1) != x1e)
                    $display("FAIL rnd_crop got %0d/%0d want %0d/%0d", oCROP_X0, oCROP_X1, x0e, x1e);
                else n_pass++;
                capture_frame(5);
                n_chk++;
                if (cap_cnt != V_ACT * (x1e - x0e + 1) || cap_bad != 0 || done_cnt != 1)
                    $display("FAIL rnd_cap got %0d/%0d/%0d want %0d/0/1", cap_cnt, cap_bad, done_cnt,
                             V_ACT * (x1e - x0e + 1));
                else n_pass++;
            end else if (res == 2) begin
                n_chk++;
                if (err_cnt != 1 || oSTATE !== 3'd0)
                    $display("FAIL rnd_err got %0d st%0d want 1 st0", err_cnt, oSTATE);
                else n_pass++;
            end else begin
                n_chk++;
                if (oSTATE !== 3'd2 || err_cnt != 0)
                    $display("FAIL rnd_pending got st%0d err%0d want st2 err0", oSTATE, err_cnt);
                else n_pass++;
                pixel(1'b0, 1'b0, 1'b1);
                m_stable = 0;
                m_miss = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restabilise();
        test_saturate();
        test_nohit();
        test_abort();
        test_midframe_start();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
